// File: rtl/flit_valid_buffer.sv
// Router input stage: keeps only flits whose MSB valid flag is set in a small
// first-word-fall-through queue, and drops and counts valid flits that arrive while it is full.
module flit_valid_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DATA_WIDTH:0]        flit_i,
    output logic                       ready_o,
    output logic [DATA_WIDTH:0]        data_o,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       drop_o,
    output logic [CNT_WIDTH-1:0]       drop_cnt_o
);

    localparam int PTR_WIDTH   = $clog2(DEPTH);
    localparam int COUNT_WIDTH = PTR_WIDTH + 1;
    localparam logic [COUNT_WIDTH-1:0] FULL_COUNT = COUNT_WIDTH'(DEPTH);

    logic [DATA_WIDTH:0]      mem_reg [DEPTH];
    logic [DEPTH-1:0]         wr_en;
    logic [PTR_WIDTH-1:0]     wr_ptr_reg, wr_ptr_next;
    logic [PTR_WIDTH-1:0]     rd_ptr_reg, rd_ptr_next;
    logic [COUNT_WIDTH-1:0]   count_reg, count_next;
    logic                     drop_reg, drop_next;
    logic [CNT_WIDTH-1:0]     drop_cnt_reg, drop_cnt_next;
    logic                     full, empty, push, pop, drop;

    // Acceptance looks only at registered occupancy: no bypass when a pop frees a slot.
    always_comb begin
        full  = (count_reg == FULL_COUNT);
        empty = (count_reg == '0);
        push  = flit_i[DATA_WIDTH] && !full;
        drop  = flit_i[DATA_WIDTH] && full;
        pop   = !empty && ready_i;
    end

    always_comb begin
        wr_ptr_next   = push ? wr_ptr_reg + PTR_WIDTH'(1) : wr_ptr_reg;
        rd_ptr_next   = pop  ? rd_ptr_reg + PTR_WIDTH'(1) : rd_ptr_reg;
        count_next    = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + COUNT_WIDTH'(1);
            2'b01:   count_next = count_reg - COUNT_WIDTH'(1);
            default: count_next = count_reg;
        endcase
        drop_next     = drop;
        drop_cnt_next = (drop && (drop_cnt_reg != '1)) ? drop_cnt_reg + CNT_WIDTH'(1)
                                                       : drop_cnt_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            drop_reg     <= 1'b0;
            drop_cnt_reg <= '0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            drop_reg     <= drop_next;
            drop_cnt_reg <= drop_cnt_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_wr_en
            assign wr_en[gi] = push && (wr_ptr_reg == PTR_WIDTH'(gi));
        end
    endgenerate

    // Storage is left unreset; its contents are invisible while the queue is empty.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en[i]) mem_reg[i] <= flit_i;
        end
    end

    assign data_o     = empty ? '0 : mem_reg[rd_ptr_reg];
    assign valid_o    = !empty;
    assign ready_o    = !full;
    assign count_o    = count_reg;
    assign drop_o     = drop_reg;
    assign drop_cnt_o = drop_cnt_reg;

endmodule

// File: tb/tb_flit_valid_buffer.sv
// Bench for flit_valid_buffer: directed and random flits checked each cycle against a queue model;
// a second instance with a 2-bit drop counter shares the stimulus to exercise saturation.
module tb_flit_valid_buffer;

    localparam int DW    = 16;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW:0]   flit_i = '0;
    logic          ready_i = 1'b0;

    logic          ready_o, valid_o, drop_o;
    logic [DW:0]   data_o;
    logic [2:0]    count_o;
    logic [7:0]    drop_cnt_o;

    logic          ready2, valid2, drop2;
    logic [DW:0]   data2;
    logic [2:0]    count2;
    logic [1:0]    drop_cnt2;

    flit_valid_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .flit_i(flit_i), .ready_o(ready_o), .data_o(data_o),
        .valid_o(valid_o), .ready_i(ready_i), .count_o(count_o), .drop_o(drop_o),
        .drop_cnt_o(drop_cnt_o)
    );

    flit_valid_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(2)) u_dut_sat (
        .clk(clk), .rst_n(rst_n), .flit_i(flit_i), .ready_o(ready2), .data_o(data2),
        .valid_o(valid2), .ready_i(ready_i), .count_o(count2), .drop_o(drop2),
        .drop_cnt_o(drop_cnt2)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: queue contents, drop pulse, and saturating drop totals.
    logic [DW:0] q[$];
    bit          m_drop = 1'b0;
    int          m_dcnt = 0;
    int          m_dcnt2 = 0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_all();
        logic [DW:0] exp_data;
        exp_data = (q.size() != 0) ? q[0] : '0;
        check("valid_o",    32'(valid_o),    32'(q.size() != 0));
        check("data_o",     32'(data_o),     32'(exp_data));
        check("ready_o",    32'(ready_o),    32'(q.size() != DEPTH));
        check("count_o",    32'(count_o),    32'(q.size()));
        check("drop_o",     32'(drop_o),     32'(m_drop));
        check("drop_cnt_o", 32'(drop_cnt_o), 32'(m_dcnt));
        check("sat_data_o", 32'(data2),      32'(exp_data));
        check("sat_valid",  32'(valid2),     32'(q.size() != 0));
        check("sat_ready",  32'(ready2),     32'(q.size() != DEPTH));
        check("sat_count",  32'(count2),     32'(q.size()));
        check("sat_drop_o", 32'(drop2),      32'(m_drop));
        check("sat_dcnt",   32'(drop_cnt2),  32'(m_dcnt2));
    endtask

    // Called just after a falling edge: drive, check registered outputs, clock, update model.
    task automatic step(input logic [DW:0] f, input logic r);
        bit v, full, empty;
        flit_i  = f;
        ready_i = r;
        check_all();
        @(posedge clk);
        v     = f[DW];
        full  = (q.size() == DEPTH);
        empty = (q.size() == 0);
        m_drop = v && full;
        if (m_drop) begin
            if (m_dcnt < 255) m_dcnt++;
            if (m_dcnt2 < 3) m_dcnt2++;
        end
        if (!empty && r) void'(q.pop_front());
        if (v && !full) q.push_back(f);
        @(negedge clk);
    endtask

    task automatic model_reset();
        q.delete();
        m_drop  = 1'b0;
        m_dcnt  = 0;
        m_dcnt2 = 0;
    endtask

    initial begin
        logic [DW:0] f;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Invalid flits with all payload bits set are ignored.
        for (int i = 0; i < 10; i++) step(17'h0_FFFF, 1'b0);

        // Three pushes held, then drained in order.
        step(17'h1_00A1, 1'b0);
        step(17'h1_00A2, 1'b0);
        step(17'h1_00A3, 1'b0);
        for (int i = 0; i < 4; i++) step(17'h0_0000, 1'b1);

        // Fill, then overflow with BEEF.
        for (int i = 0; i < DEPTH; i++) step({1'b1, 16'hB000 + 16'(i)}, 1'b0);
        step(17'h1_BEEF, 1'b0);
        step(17'h0_0000, 1'b0);

        // Full with a same-cycle pop: flit still dropped, count falls to 3.
        step(17'h1_CAFE, 1'b1);
        for (int i = 0; i < 20; i++) step({1'b1, 16'h5000 + 16'(i)}, 1'b1);
        for (int i = 0; i < 5; i++) step(17'h0_0000, 1'b1);

        // Five more drops push the 2-bit counter into saturation.
        for (int i = 0; i < DEPTH; i++) step({1'b1, 16'hC000 + 16'(i)}, 1'b0);
        for (int i = 0; i < 5; i++) step({1'b1, 16'hD000 + 16'(i)}, 1'b0);
        step(17'h0_0000, 1'b0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            f = {($urandom_range(0, 3) != 0), 16'($urandom)};
            step(f, 1'($urandom_range(0, 1)));
        end

        // Drain, leave two entries, then reset between clock edges.
        for (int i = 0; i < 6; i++) step(17'h0_0000, 1'b1);
        step(17'h1_1111, 1'b0);
        step(17'h1_2222, 1'b0);
        check_all();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        step(17'h1_3333, 1'b0);
        step(17'h0_0000, 1'b1);
        step(17'h0_0000, 1'b0);
        check_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
